data_memory_banked: RTL and testbench

//  Parametrised single-port data memory for the 16-bit FSM CPU, the next

---
 rtl/data_memory_banked.sv | 131 +++++++++++++
 tb/tb_data_memory_banked.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_banked.sv
// data_memory_banked: single-port data memory for the 16-bit FSM CPU with
// byte-enable writes, valid/ready requests, one-cycle registered responses,
// an out-of-range error flag and a post-reset sequential clear sweep.
module data_memory_banked #(
    parameter int unsigned  DATA_W         = 16,
    parameter int unsigned  ADDR_W         = 8,
    parameter int unsigned  DEPTH          = 256,
    parameter bit           CLEAR_ON_RESET = 1'b1,
    localparam int unsigned BE_W           = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_in_range;
    logic                w_clear_last;
    logic [IDX_W-1:0]    w_req_idx;
    logic [IDX_W-1:0]    w_clr_idx;
    logic [DATA_W-1:0]   w_cur_word;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_rsp_word;
    logic                w_ready_next;
    logic                w_busy_next;

    assign w_accept     = req_valid && req_ready;
    assign w_in_range   = (32'(req_addr) < DEPTH);
    assign w_clear_last = (32'(r_clr_ptr) == (DEPTH - 1));
    assign w_req_idx    = IDX_W'(req_addr);
    assign w_clr_idx    = IDX_W'(r_clr_ptr);
    assign w_cur_word   = w_in_range ? r_mem[w_req_idx] : '0;
    assign w_rsp_word   = w_in_range ? w_merged : '0;

    // Merge enabled write lanes over the current word; reads pass it through
    always_comb begin
        w_merged = w_cur_word;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (req_we && req_be[i]) begin
                w_merged[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end
    end

    // Next-state and next-output decode for the clear/ready controller
    always_comb begin
        w_state_next = r_state;
        w_ready_next = 1'b0;
        w_busy_next  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (w_clear_last) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                w_state_next = ST_READY;
            end
            default: begin
                w_state_next = ST_READY;
            end
        endcase
        w_ready_next = (w_state_next == ST_READY);
        w_busy_next  = (w_state_next == ST_CLEAR);
    end

    // State register and clear pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
            end
        end
    end

    // Registered handshake, status and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready <= 1'b0;
            busy      <= CLEAR_ON_RESET;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            req_ready <= w_ready_next;
            busy      <= w_busy_next;
            rsp_valid <= w_accept;
            rsp_err   <= w_accept && !w_in_range;
            if (w_accept) begin
                rsp_rdata <= w_rsp_word;
            end
        end
    end

    // Memory array: sweep clear or in-range request write; rst leaves contents alone
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[w_clr_idx] <= '0;
            end else if (w_accept && req_we && w_in_range) begin
                r_mem[w_req_idx] <= w_merged;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_banked.sv
// Bench for data_memory_banked: three instances (default, DEPTH=200,
// CLEAR_ON_RESET=0) checked every cycle against a cycle-count based model,
// plus directed literal expectations.
module tb_data_memory_banked;

    localparam int NI = 3;

    logic        clk;
    logic        rst       [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [7:0]  req_addr  [NI];
    logic [15:0] req_wdata [NI];
    logic [1:0]  req_be    [NI];
    logic        rsp_valid [NI];
    logic [15:0] rsp_rdata [NI];
    logic        rsp_err   [NI];
    logic        busy      [NI];

    int n_cmp  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned D = (g == 1) ? 200 : 256;
        localparam bit          C = (g == 2) ? 1'b0 : 1'b1;
        data_memory_banked #(
            .DATA_W(16), .ADDR_W(8), .DEPTH(D), .CLEAR_ON_RESET(C)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be   (req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g]),
            .busy     (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dep(int k);
        return (k == 1) ? 200 : 256;
    endfunction

    function automatic bit cor(int k);
        return (k != 2);
    endfunction

    // Model state: edges since reset released, memory image, expected response
    int          m_cnt   [NI];
    logic [15:0] m_mem   [NI][256];
    logic        m_valid [NI];
    logic [15:0] m_rdata [NI];
    logic        m_err   [NI];

    initial begin
        for (int k = 0; k < NI; k++) begin
            m_cnt[k] = 0; m_valid[k] = 0; m_rdata[k] = 0; m_err[k] = 0;
            for (int a = 0; a < 256; a++) m_mem[k][a] = 16'h0;
        end
    end

    function automatic bit m_ready(int k);
        return m_cnt[k] >= (cor(k) ? dep(k) : 1);
    endfunction

    function automatic bit m_busy(int k);
        return cor(k) && (m_cnt[k] < dep(k));
    endfunction

    // Behavioural model advanced on each rising edge
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst[k]) begin
                m_cnt[k] = 0; m_valid[k] = 0; m_rdata[k] = 0; m_err[k] = 0;
            end else begin
                logic        acc;
                logic [15:0] w;
                acc = req_valid[k] && m_ready(k);
                if (cor(k) && m_cnt[k] < dep(k)) m_mem[k][m_cnt[k]] = 16'h0;
                m_valid[k] = acc;
                m_err[k]   = 1'b0;
                if (acc) begin
                    if (int'(req_addr[k]) >= dep(k)) begin
                        m_err[k]   = 1'b1;
                        m_rdata[k] = 16'h0;
                    end else begin
                        w = m_mem[k][req_addr[k]];
                        if (req_we[k]) begin
                            if (req_be[k][0]) w[7:0]  = req_wdata[k][7:0];
                            if (req_be[k][1]) w[15:8] = req_wdata[k][15:8];
                            m_mem[k][req_addr[k]] = w;
                        end
                        m_rdata[k] = w;
                    end
                end
                if (m_cnt[k] < 1000000) m_cnt[k] = m_cnt[k] + 1;
            end
        end
    end

    task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, k, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            chk("req_ready", k, 32'(req_ready[k]), 32'(m_ready(k)));
            chk("busy",      k, 32'(busy[k]),      32'(m_busy(k)));
            chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(m_valid[k]));
            chk("rsp_err",   k, 32'(rsp_err[k]),   32'(m_err[k]));
            chk("rsp_rdata", k, 32'(rsp_rdata[k]), 32'(m_rdata[k]));
        end
    endtask

    // One cycle: wait for the falling edge, then compare everything
    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic req(int k, bit we, logic [7:0] a, logic [15:0] d, logic [1:0] be);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = a;
        req_wdata[k] = d;
        req_be[k]    = be;
        tick();
        req_valid[k] = 1'b0;
    endtask

    // Directed stimulus with hand-computed literal expectations
    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = 8'h0; req_wdata[k] = 16'h0; req_be[k] = 2'b00;
        end
        tick();
        chk("lit_rst_ready", 0, 32'(req_ready[0]), 32'd0);
        chk("lit_rst_busy",  0, 32'(busy[0]),      32'd1);
        chk("lit_rst_busy",  2, 32'(busy[2]),      32'd0);
        tick();
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;

        // Sweep lasts 256 cycles on the default instance
        repeat (255) tick();
        chk("lit_sweep_busy",  0, 32'(busy[0]),      32'd1);
        chk("lit_sweep_ready", 0, 32'(req_ready[0]), 32'd0);
        tick();
        chk("lit_done_busy",  0, 32'(busy[0]),      32'd0);
        chk("lit_done_ready", 0, 32'(req_ready[0]), 32'd1);
        req(0, 1'b0, 8'hFF, 16'h0, 2'b00);
        chk("lit_rd_ff_valid", 0, 32'(rsp_valid[0]), 32'd1);
        chk("lit_rd_ff_data",  0, 32'(rsp_rdata[0]), 32'h0000);

        // Write then read back-to-back
        req(0, 1'b1, 8'hA5, 16'hBEEF, 2'b11);
        chk("lit_wr_a5", 0, 32'(rsp_rdata[0]), 32'hBEEF);
        req(0, 1'b0, 8'hA5, 16'h0, 2'b00);
        chk("lit_rd_a5", 0, 32'(rsp_rdata[0]), 32'hBEEF);
        chk("lit_rd_a5_valid", 0, 32'(rsp_valid[0]), 32'd1);

        // Byte-enable merges
        req(0, 1'b1, 8'h07, 16'h1234, 2'b11);
        req(0, 1'b1, 8'h07, 16'hABCD, 2'b10);
        chk("lit_be10", 0, 32'(rsp_rdata[0]), 32'hAB34);
        req(0, 1'b1, 8'h07, 16'hFFFF, 2'b00);
        chk("lit_be00", 0, 32'(rsp_rdata[0]), 32'hAB34);
        req(0, 1'b0, 8'h07, 16'h0, 2'b00);
        chk("lit_rd7", 0, 32'(rsp_rdata[0]), 32'hAB34);
        req(0, 1'b1, 8'h07, 16'h99CD, 2'b01);
        chk("lit_be01", 0, 32'(rsp_rdata[0]), 32'hABCD);
        tick();
        chk("lit_idle_valid", 0, 32'(rsp_valid[0]), 32'd0);
        chk("lit_idle_hold",  0, 32'(rsp_rdata[0]), 32'hABCD);

        // Out-of-range on DEPTH=200
        req(1, 1'b0, 8'd210, 16'h0, 2'b00);
        chk("lit_oor_rd_err",  1, 32'(rsp_err[1]),   32'd1);
        chk("lit_oor_rd_data", 1, 32'(rsp_rdata[1]), 32'h0);
        req(1, 1'b1, 8'd210, 16'h7777, 2'b11);
        chk("lit_oor_wr_err",  1, 32'(rsp_err[1]),   32'd1);
        req(1, 1'b0, 8'd10, 16'h0, 2'b00);
        chk("lit_alias10", 1, 32'(rsp_rdata[1]), 32'h0);
        chk("lit_alias10_err", 1, 32'(rsp_err[1]), 32'd0);
        req(1, 1'b1, 8'd199, 16'hC0DE, 2'b11);
        chk("lit_last_ok", 1, 32'(rsp_rdata[1]), 32'hC0DE);
        req(1, 1'b0, 8'd200, 16'h0, 2'b00);
        chk("lit_first_oor", 1, 32'(rsp_err[1]), 32'd1);

        // Reset restarts the sweep; request on the reset edge is dropped
        req(0, 1'b1, 8'h05, 16'h5A5A, 2'b11);
        chk("lit_wr5", 0, 32'(rsp_rdata[0]), 32'h5A5A);
        rst[0] = 1'b1;
        req(0, 1'b1, 8'h05, 16'h1111, 2'b11);
        chk("lit_drop_valid", 0, 32'(rsp_valid[0]), 32'd0);
        rst[0] = 1'b0;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 8'h05;
        repeat (100) tick();
        req_valid[0] = 1'b0;
        chk("lit_mid_busy", 0, 32'(busy[0]), 32'd1);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        repeat (255) tick();
        chk("lit_resweep_busy", 0, 32'(busy[0]), 32'd1);
        tick();
        chk("lit_resweep_done", 0, 32'(busy[0]), 32'd0);
        req(0, 1'b0, 8'h05, 16'h0, 2'b00);
        chk("lit_rd5_cleared", 0, 32'(rsp_rdata[0]), 32'h0);
        req(0, 1'b0, 8'hA5, 16'h0, 2'b00);
        chk("lit_rda5_cleared", 0, 32'(rsp_rdata[0]), 32'h0);

        // No clear: contents survive reset
        req(2, 1'b1, 8'h03, 16'h5555, 2'b11);
        rst[2] = 1'b1;
        tick();
        chk("lit_nc_rst_ready", 2, 32'(req_ready[2]), 32'd0);
        rst[2] = 1'b0;
        tick();
        chk("lit_nc_ready", 2, 32'(req_ready[2]), 32'd1);
        req(2, 1'b0, 8'h03, 16'h0, 2'b00);
        chk("lit_nc_rd3", 2, 32'(rsp_rdata[2]), 32'h5555);
        req(2, 1'b1, 8'h04, 16'h0F0F, 2'b11);
        req(2, 1'b0, 8'h04, 16'h0, 2'b00);
        chk("lit_nc_rd4", 2, 32'(rsp_rdata[2]), 32'h0F0F);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
